ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter for the OMDAZZ keyboard port. It sends one command byte to the keyboard, for example 0xED set-LEDs, 0xFF reset or 0xF4 enable, using the PS/2 request-to-send sequence. It drives both lines open-drain and reports the device ACK. It is fully synchronous to clk and sits beside the existing PS/2 scan-code receiver on the same two wires. The receiver must ignore traffic while `busy`=1.

## Interface
- `INHIBIT_CYCLES`, default 6000: clk cycles the clock line is held low before RTS (120 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum clk cycles allowed between device clock falling edges, and before the first one (15 ms at 50 MHz).
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `tx_valid`, in, 1: command byte available.
- `tx_byte`, in, 8: command byte.
- `tx_ready`, out, 1: block idle; a command is accepted when `tx_valid && tx_ready`.
- `ps2k_clk_in`, in, 1: PS/2 clock pin, read back.
- `ps2k_data_in`, in, 1: PS/2 data pin, read back.
- `ps2k_clk_oe`, out, 1: 1 = drive clock pin low; 0 = release the pin (pulled up).
- `ps2k_data_oe`, out, 1: 1 = drive data pin low; 0 = release the pin.
- `busy`, out, 1: transaction in progress (inverse of `tx_ready`).
- `done`, out, 1: one-cycle pulse when a frame completes.
- `ack_ok`, out, 1: ACK sampled low by the device; valid in the `done` cycle and held until the next accept.
- `error`, out, 1: one-cycle pulse on timeout.

## Operation
- **Pin inputs:** both pins pass through a 2-FF synchronizer. A falling edge `fe` is registered when the previous synced value is 1 and the current one is 0.
- **Frame register:** on accept, 10 bits are loaded, `{1'b1 stop, ~^tx_byte odd parity, tx_byte}`. A 4-bit edge counter `n` is cleared.
- **IDLE:** both `oe`=0, `tx_ready`=1. On accept, go to INHIBIT.
- **INHIBIT:** `clk_oe`=1, `data_oe`=0 for `INHIBIT_CYCLES` cycles, then go to RTS.
- **RTS:** `clk_oe`=1, `data_oe`=1 (start bit) for exactly 1 cycle, then go to SEND. The timeout counter is cleared.
- **SEND:** `clk_oe`=0. On each `fe`, `n` increments:
  - n=1..10: `data_oe` ← ~frame[0], then the frame shifts right. Data bits go LSB first, then parity, then the stop bit (`data_oe`=0).
  - n=11: `ack_ok` ← ~synced data. Go to WAIT_IDLE.
- **WAIT_IDLE:** both `oe`=0. When the synced clock and data are both 1, pulse `done` and go to IDLE.
- **Timeout:** a counter runs in SEND and WAIT_IDLE and clears on every `fe`. On reaching `TIMEOUT_CYCLES`:
  - release both lines, pulse `error`, set `ack_ok`=0, go to IDLE;
  - `done` does not pulse.
- **Simultaneous events:** `tx_valid` outside IDLE is ignored; there is no queuing. A timeout and `fe` in the same cycle resolve as `fe`, with the timer cleared.
- **Reset, including mid-frame:** state IDLE; `ps2k_clk_oe`=0, `ps2k_data_oe`=0, `busy`=0, `tx_ready`=1, `done`=0, `ack_ok`=0, `error`=0; counters and frame cleared. The lines are released immediately.

## Timing
- **Accept to inhibit:** `clk_oe` rises on the first clk edge after the accept cycle.
- **Inhibit length:** `clk_oe` is high for `INHIBIT_CYCLES`+1 cycles; the last cycle overlaps `data_oe`=1.
- **Edge latency:** `fe` is seen 3 clk cycles after the pin falls (2 sync stages plus the edge register). `data_oe` updates in the cycle after `fe`.
- **Completion:** `done` occurs 1 cycle after both synced lines are seen high in WAIT_IDLE.
- **Outputs:** all outputs are registered except `tx_ready` and `busy`, which decode the state.
- **Widths:** counters are `$clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1)` bits. No wrap is possible because each counter saturates at its terminal value.

## Structure
- **Package `ps2_pkg`:**
  - state enum: IDLE, INHIBIT, RTS, SEND, WAIT_IDLE;
  - `PS2_FRAME_BITS`=11;
  - command constants `PS2_CMD_RESET`=8'hFF, `PS2_CMD_SET_LEDS`=8'hED, `PS2_CMD_ENABLE`=8'hF4, `PS2_RSP_ACK`=8'hFA.
- **Sub-module `ps2_line_sync`:** 2-FF synchronizer plus falling-edge detect, instantiated once for clock and once for data. It is reusable by the receiver.

## Test plan
Bench settings: `INHIBIT_CYCLES`=8, `TIMEOUT_CYCLES`=200. A device model clocks with a period of 40 cycles.

1. **Send 0xED:**
   - `clk_oe` high for 9 cycles, then 1 RTS cycle with `data_oe`=1.
   - Device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
   - Device ACKs low, giving `done`=1 and `ack_ok`=1.
2. **Send 0x00:** parity bit sampled as 1; stop bit released.
3. **No ACK:** device leaves data high at edge 11 → `done` pulses with `ack_ok`=0.
4. **No device clock after RTS:** `error` pulses 200 cycles after SEND entry; both `oe`=0; `tx_ready`=1.
5. **`rst_n` low mid-frame** (after edge 5): both `oe`=0 asynchronously; a new accept after reset produces a clean full frame.
6. **`tx_valid` held high during a transaction:** only one frame is sent. A second accept happens only after `done`, with `tx_byte` re-read.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame sizing and
// common command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        WAIT_IDLE
    } ps2_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;
    // Bits the host shifts out after the start bit: data, parity, stop.
    localparam int unsigned PS2_SHIFT_BITS = PS2_FRAME_BITS - 1;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

    // Shift payload {stop, odd parity, data}; bit 0 leaves first.
    function automatic logic [PS2_SHIFT_BITS-1:0] ps2_frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-stage synchronizer for one PS/2 line plus a registered falling-edge
// strobe; lines idle high, so the stages reset to 1.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_in,
    output logic level,
    output logic fe
);

    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic fe_q;
    logic fe_d;

    always_comb begin
        fe_d = s3_q & ~s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
            fe_q <= 1'b0;
        end else begin
            s1_q <= pin_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
            fe_q <= fe_d;
        end
    end

    assign level = s2_q;
    assign fe    = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift the
// frame on device clock falls, capture the ACK and wait for the bus to idle.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_byte,
    output logic       tx_ready,
    input  logic       ps2k_clk_in,
    input  logic       ps2k_data_in,
    output logic       ps2k_clk_oe,
    output logic       ps2k_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                         : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT = 4'(PS2_SHIFT_BITS);

    ps2_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [3:0]                n_q, n_d;
    logic [PS2_SHIFT_BITS-1:0] frame_q, frame_d;
    logic clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic done_q, done_d, ack_ok_q, ack_ok_d, error_q, error_d;

    logic clk_lvl, clk_fe, data_lvl, data_fe_unused;

    ps2_line_sync u_clk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (ps2k_clk_in),
        .level  (clk_lvl),
        .fe     (clk_fe)
    );

    ps2_line_sync u_data_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (ps2k_data_in),
        .level  (data_lvl),
        .fe     (data_fe_unused)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        frame_d   = frame_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ack_ok_d  = ack_ok_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        cnt_inc   = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    state_d  = INHIBIT;
                    frame_d  = ps2_frame(tx_byte);
                    n_d      = 4'd0;
                    cnt_d    = '0;
                    ack_ok_d = 1'b0;
                    clk_oe_d = 1'b1;
                end
            end
            INHIBIT: begin
                cnt_d = cnt_inc;
                if (cnt_q == INH_LAST) begin
                    state_d   = RTS;
                    data_oe_d = 1'b1;
                end
            end
            RTS: begin
                // Start bit stays driven until the device's first clock fall.
                state_d  = SEND;
                clk_oe_d = 1'b0;
                cnt_d    = '0;
            end
            SEND: begin
                if (clk_fe) begin
                    cnt_d = '0;
                    n_d   = n_q + 4'd1;
                    if (n_q == LAST_BIT) begin
                        ack_ok_d  = ~data_lvl;
                        data_oe_d = 1'b0;
                        state_d   = WAIT_IDLE;
                    end else begin
                        data_oe_d = ~frame_q[0];
                        frame_d   = frame_q >> 1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d   = IDLE;
                    data_oe_d = 1'b0;
                    ack_ok_d  = 1'b0;
                    error_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_IDLE: begin
                if (clk_lvl && data_lvl) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (clk_fe) begin
                    cnt_d = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d  = IDLE;
                    ack_ok_d = 1'b0;
                    error_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d   = IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            n_q       <= 4'd0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ack_ok_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            frame_q   <= frame_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            ack_ok_q  <= ack_ok_d;
            error_q   <= error_d;
        end
    end

    assign tx_ready     = (state_q == IDLE);
    assign busy         = ~tx_ready;
    assign ps2k_clk_oe  = clk_oe_q;
    assign ps2k_data_oe = data_oe_q;
    assign done         = done_q;
    assign ack_ok       = ack_ok_q;
    assign error        = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a PS/2 device model, a
// timestamp-based reference of the host's pin behaviour, and directed plus
// random command transactions.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH  = 8;
    localparam int unsigned TO   = 200;
    localparam int unsigned HALF = 20;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_byte  = 8'h00;
    logic       tx_ready, busy, done, ack_ok, error;
    logic       ps2k_clk_in, ps2k_data_in, ps2k_clk_oe, ps2k_data_oe;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    assign ps2k_clk_in  = ~(ps2k_clk_oe | dev_clk_low);
    assign ps2k_data_in = ~(ps2k_data_oe | dev_data_low);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_valid     (tx_valid),
        .tx_byte      (tx_byte),
        .tx_ready     (tx_ready),
        .ps2k_clk_in  (ps2k_clk_in),
        .ps2k_data_in (ps2k_data_in),
        .ps2k_clk_oe  (ps2k_clk_oe),
        .ps2k_data_oe (ps2k_data_oe),
        .busy         (busy),
        .done         (done),
        .ack_ok       (ack_ok),
        .error        (error)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkw(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) (cycle %0d)",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Bit the device must see at clock edge k: data LSB first, odd parity, stop.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k <= 8) return b[3'(k - 1)];
        if (k == 9) return ~^b;
        return 1'b1;
    endfunction

    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        logic [9:0] f;
        for (int k = 1; k <= 10; k++) f[4'(k - 1)] = exp_bit(b, k);
        return f;
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    logic [7:0] hc, hd;          // pin history, [k] = value k cycles ago
    logic       m_active, m_wait;
    logic [7:0] m_byte;
    int         m_t, m_acc, m_ref, m_edges;
    logic       e_clk_oe = 1'b0, e_data_oe = 1'b0, e_done = 1'b0, e_ack = 1'b0, e_err = 1'b0;
    logic       m_fe, m_lc, m_ld;

    always @(negedge clk) begin
        if (!rst_n) begin
            check1("rst_clk_oe", ps2k_clk_oe, 1'b0);
            check1("rst_data_oe", ps2k_data_oe, 1'b0);
            check1("rst_done", done, 1'b0);
            check1("rst_ack_ok", ack_ok, 1'b0);
            check1("rst_error", error, 1'b0);
            check1("rst_tx_ready", tx_ready, 1'b1);
            check1("rst_busy", busy, 1'b0);
            hc = 8'hFF; hd = 8'hFF;
            m_active = 1'b0; m_wait = 1'b0; m_t = 0;
            e_clk_oe = 1'b0; e_data_oe = 1'b0; e_done = 1'b0; e_ack = 1'b0; e_err = 1'b0;
        end else begin
            check1("clk_oe", ps2k_clk_oe, e_clk_oe);
            check1("data_oe", ps2k_data_oe, e_data_oe);
            check1("done", done, e_done);
            check1("ack_ok", ack_ok, e_ack);
            check1("error", error, e_err);
            check1("tx_ready", tx_ready, !m_active);
            check1("busy", busy, m_active);

            hc = {hc[6:0], ps2k_clk_in};
            hd = {hd[6:0], ps2k_data_in};
            m_fe = hc[4] & ~hc[3];
            m_lc = hc[2];
            m_ld = hd[2];
            e_done = 1'b0;
            e_err  = 1'b0;

            if (!m_active) begin
                e_clk_oe  = 1'b0;
                e_data_oe = 1'b0;
                if (tx_valid) begin
                    m_active = 1'b1; m_wait = 1'b0; m_acc = m_t; m_edges = 0;
                    m_byte = tx_byte; e_ack = 1'b0; e_clk_oe = 1'b1;
                end
            end else if (m_t < m_acc + int'(INH)) begin
                e_clk_oe = 1'b1; e_data_oe = 1'b0;
            end else if (m_t == m_acc + int'(INH)) begin
                e_clk_oe = 1'b1; e_data_oe = 1'b1;
            end else if (m_t == m_acc + int'(INH) + 1) begin
                e_clk_oe = 1'b0; e_data_oe = 1'b1; m_ref = m_t + 1;
            end else if (!m_wait) begin
                if (m_fe) begin
                    m_edges++;
                    m_ref = m_t + 1;
                    if (m_edges <= 10) e_data_oe = ~exp_bit(m_byte, m_edges);
                    else begin
                        e_data_oe = 1'b0; e_ack = ~m_ld; m_wait = 1'b1;
                    end
                end else if (m_t + 1 - m_ref == int'(TO)) begin
                    e_err = 1'b1; e_data_oe = 1'b0; e_ack = 1'b0; m_active = 1'b0;
                end
            end else begin
                if (m_lc && m_ld) begin
                    e_done = 1'b1; m_active = 1'b0;
                end else if (m_fe) begin
                    m_ref = m_t + 1;
                end else if (m_t + 1 - m_ref == int'(TO)) begin
                    e_err = 1'b1; e_ack = 1'b0; m_active = 1'b0;
                end
            end
            m_t++;
        end
    end

    // Inhibit run length and RTS overlap of the most recent transaction.
    int oe_run = 0, ovl_run = 0, last_run = 0, last_ovl = 0, n_done = 0, n_err = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            oe_run = 0; ovl_run = 0;
        end else begin
            if (ps2k_clk_oe) begin
                oe_run++;
                if (ps2k_data_oe) ovl_run++;
            end else if (oe_run > 0) begin
                last_run = oe_run; last_ovl = ovl_run; oe_run = 0; ovl_run = 0;
            end
            if (done)  n_done++;
            if (error) n_err++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [7:0] b);
        tick(1);
        tx_valid = 1'b1; tx_byte = b;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_ready) begin ok = 1'b1; break; end
        end
        check1("idle_wait", ok, 1'b1);
        tick(2);
    endtask

    // Device: mode 0 ACK, 1 no ACK, 2 never clocks, 3 stops after edge 5.
    task automatic dev_frame(input int mode, output logic [9:0] got);
        logic seen;
        seen = 1'b0;
        got  = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ps2k_clk_in && !ps2k_data_in) begin seen = 1'b1; break; end
        end
        check1("dev_start", seen, 1'b1);
        if (seen && mode != 2) begin
            tick(int'($urandom_range(20, 2)));
            for (int k = 1; k <= 11; k++) begin
                if (k == 11 && mode == 0) dev_data_low = 1'b1;
                dev_clk_low = 1'b1;
                tick(HALF);
                dev_clk_low = 1'b0;
                if (k <= 10) got[4'(k - 1)] = ps2k_data_in;
                if (k == 11) dev_data_low = 1'b0;
                tick(HALF);
                if (mode == 3 && k == 5) break;
            end
        end
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] got, g1, g2;
        logic [7:0] b, b1, b2;
        logic       ok;
        int         d0, cnt, mode;

        #1 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Set-LEDs command with ACK
        pulse(PS2_CMD_SET_LEDS);
        dev_frame(0, got);
        wait_idle();
        checkw("ed_frame", int'(got), 10'b11_1110_1101);
        checkw("ed_inhibit_len", last_run, 9);
        checkw("ed_rts_overlap", last_ovl, 1);
        check1("ed_ack_ok", ack_ok, 1'b1);

        // All-zero byte: parity 1, stop released
        pulse(8'h00);
        dev_frame(0, got);
        wait_idle();
        checkw("zero_frame", int'(got), 10'b11_0000_0000);

        // Device never ACKs
        d0 = n_done;
        pulse(PS2_CMD_ENABLE);
        dev_frame(1, got);
        wait_idle();
        checkw("noack_frame", int'(got), int'(exp_frame(PS2_CMD_ENABLE)));
        check1("noack_ack_ok", ack_ok, 1'b0);
        checkw("noack_done_count", n_done, d0 + 1);

        // Device never clocks: timeout
        d0 = n_err;
        pulse(PS2_CMD_RESET);
        dev_frame(2, got);
        cnt = 0; ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cnt++;
            if (error) begin ok = 1'b1; break; end
        end
        check1("timeout_seen", ok, 1'b1);
        checkw("timeout_delay", cnt, int'(TO));
        check1("timeout_clk_oe", ps2k_clk_oe, 1'b0);
        check1("timeout_data_oe", ps2k_data_oe, 1'b0);
        check1("timeout_tx_ready", tx_ready, 1'b1);
        wait_idle();
        checkw("timeout_err_count", n_err, d0 + 1);

        // Asynchronous reset mid-frame, then a clean frame
        pulse(8'h0F);
        dev_frame(3, got);
        check1("pre_reset_data_oe", ps2k_data_oe, 1'b1);
        check1("pre_reset_busy", busy, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check1("async_clk_oe", ps2k_clk_oe, 1'b0);
        check1("async_data_oe", ps2k_data_oe, 1'b0);
        check1("async_tx_ready", tx_ready, 1'b1);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        b = 8'($urandom);
        pulse(b);
        dev_frame(0, got);
        wait_idle();
        checkw("post_reset_frame", int'(got), int'(exp_frame(b)));

        // tx_valid held through a transaction: exactly one re-accept after done
        d0 = n_done;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        tick(1);
        tx_valid = 1'b1; tx_byte = b1;
        tick(1);
        tx_byte = b2;
        fork
            begin
                dev_frame(0, g1);
                dev_frame(0, g2);
            end
            begin
                logic seen_done;
                seen_done = 1'b0;
                for (int i = 0; i < 3000; i++) begin
                    @(negedge clk);
                    if (done) begin seen_done = 1'b1; break; end
                end
                check1("hold_first_done", seen_done, 1'b1);
                tick(1);
                tx_valid = 1'b0;
            end
        join
        wait_idle();
        checkw("hold_frame1", int'(g1), int'(exp_frame(b1)));
        checkw("hold_frame2", int'(g2), int'(exp_frame(b2)));
        checkw("hold_done_count", n_done, d0 + 2);

        // Random commands, gaps and ACK behaviour
        for (int i = 0; i < 14; i++) begin
            b    = 8'($urandom);
            mode = int'($urandom_range(1, 0));
            tick(int'($urandom_range(5, 0)));
            pulse(b);
            dev_frame(mode, got);
            wait_idle();
            checkw("rand_frame", int'(got), int'(exp_frame(b)));
            check1("rand_ack_ok", ack_ok, mode == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
